csa_resolver: RTL
=================

// Module: csa_resolver
// PURPOSE
// - Converts a carry-save (redundant) pair from the CSA stage into a plain binary value.
// - Carry-propagate is done sequentially, CHUNK bits per cycle, to keep the adder small.
// - Sits downstream of the 3-operand CSA array; valid/ready on both sides.
// - Result = in_sum + (in_carry << 1), i.e. A+B+C for the original operands.
// PARAMETERS
// - WIDTH  4  bit width of in_sum / in_carry; result is WIDTH+2 bits
// - CHUNK  1  bits resolved per RUN cycle; 1 <= CHUNK <= WIDTH+1
// PORTS
// - clk        in   1        single clock, rising edge
// - rst        in   1        synchronous, active-high reset
// - in_valid   in   1        redundant pair present
// - in_ready   out  1        block can accept a pair
// - in_sum     in   WIDTH    CSA sum vector, bit i weight 2^i
// - in_carry   in   WIDTH    CSA carry vector, bit i weight 2^(i+1)
// - out_valid  out  1        out_result holds a resolved value
// - out_ready  in   1        consumer takes result
// - out_result out  WIDTH+2  binary sum
// BEHAVIOUR
// - Reset (rst=1 at an edge): state IDLE, in_ready=1, out_valid=0, out_result=0, counters 0.
// - Reset mid-RUN/DONE: operand discarded, no result emitted, same values as above.
// - Operands: op_a = {1'b0, in_sum}, op_b = {in_carry, 1'b0}, both WIDTH+1 bits, captured on accept.
// - P = ceil((WIDTH+1)/CHUNK) passes; default P=5.
// - FSM IDLE: in_ready=1; in_valid&&in_ready at edge k -> capture, clear run carry, RUN.
// - FSM RUN: in_ready=0; each edge adds CHUNK-bit slice of op_a + op_b + run carry,
//   writes slice into result register, updates run carry; slice index advances.
//   Last slice may be partial (upper bits treated as 0).
//   After P-th pass -> DONE; final run carry written to out_result[WIDTH+1].
// - FSM DONE: out_valid=1, out_result stable; out_valid&&out_ready at edge -> IDLE.
// - Latency: out_valid first high after edge k+P (P cycles after accept edge).
// - Throughput: one result per P+2 cycles minimum; in_ready strictly = (state==IDLE).
// - in_valid while in_ready=0 ignored; upstream holds data per valid/ready rule.
// - out_ready while out_valid=0 ignored; no output stored beyond one result.
// - out_result bits not yet written during RUN are don't-care; only sampled with out_valid.
// - No overflow possible: max 3*(2^WIDTH-1) < 2^(WIDTH+2).
// CONFIGURATION
// - CSA_RES_ZERO_SKIP_EN defined: in RUN, if all unprocessed bits of op_a and op_b
//   and run carry are 0 at an edge, the remaining result bits are written 0 and the
//   FSM goes to DONE at that edge; latency range 1..P, data-dependent.
// - Not defined: fixed latency P for every operand; no zero detection logic.
// TESTING
// - Reset: hold rst 2 cycles -> in_ready=1, out_valid=0, out_result=0.
// - in_sum=1111, in_carry=1111 -> out_result=6'b101101 (45), out_valid P=5 cycles after accept.
// - in_sum=0011, in_carry=1100 (CSA of 0101,1010,1100) -> out_result=6'b011011 (27).
// - Backpressure: out_ready=0 for 3 cycles in DONE -> out_result/out_valid stable,
//   in_ready=0; out_ready=1 -> IDLE, in_ready=1 next cycle.
// - rst pulsed 2 cycles into RUN -> out_valid never asserts, in_ready=1 after reset edge.
// - in_sum=0000,in_carry=0000: with CSA_RES_ZERO_SKIP_EN out_valid 1 cycle after accept,
//   without it 5; CHUNK=2 run of 1111/1111 -> 45 after P=3 cycles.

Source files
------------

// File: rtl/csa_resolver_if.sv
// Valid/ready bundle between the CSA array, the resolver and its consumer.
interface csa_resolver_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] out_result;

    modport master (
        output in_valid,
        output in_sum,
        output in_carry,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result
    );

    modport slave (
        input  in_valid,
        input  in_sum,
        input  in_carry,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result
    );
endinterface

// File: rtl/csa_resolver.sv
// Sequential carry-propagate of a carry-save pair, CHUNK bits per cycle.
// Optional CSA_RES_ZERO_SKIP_EN ends the run early once the remaining bits are zero.
module csa_resolver #(
    parameter int WIDTH = 4,
    parameter int CHUNK = 1
) (
    input  logic          clk,
    input  logic          rst,
    csa_resolver_if.slave bus
);
    localparam int W1 = WIDTH + 1;
    localparam int P  = (W1 + CHUNK - 1) / CHUNK;
    localparam int PW = P * CHUNK;
    localparam int IW = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] op_a_q, op_a_d;
    logic [PW-1:0] op_b_q, op_b_d;
    logic [PW:0]   res_q, res_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;

    int             base;
    logic [CHUNK-1:0] sl_a;
    logic [CHUNK-1:0] sl_b;
    logic [CHUNK:0]   sl_sum;
    logic             skip;

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        base    = int'(idx_q) * CHUNK;
        sl_a    = op_a_q[base +: CHUNK];
        sl_b    = op_b_q[base +: CHUNK];
        sl_sum  = {1'b0, sl_a} + {1'b0, sl_b}
                + {{CHUNK{1'b0}}, carry_q};
`ifdef CSA_RES_ZERO_SKIP_EN
        skip    = ((op_a_q >> base) == '0)
               && ((op_b_q >> base) == '0)
               && !carry_q;
`else
        skip    = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    op_a_d          = '0;
                    op_b_d          = '0;
                    op_a_d[W1-1:0]  = {1'b0, bus.in_sum};
                    op_b_d[W1-1:0]  = {bus.in_carry, 1'b0};
                    res_d           = '0;
                    carry_d         = 1'b0;
                    idx_d           = '0;
                    state_d         = RUN;
                end
            end
            RUN: begin
                // result was cleared on accept, so skipping leaves zeros
                if (skip) begin
                    state_d = DONE;
                end else begin
                    res_d[base +: CHUNK] = sl_sum[CHUNK-1:0];
                    if (idx_q == IW'(P - 1)) begin
                        res_d[PW] = sl_sum[CHUNK];
                        state_d   = DONE;
                    end else begin
                        carry_d = sl_sum[CHUNK];
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = res_q[WIDTH+1:0];
endmodule
